btn_input_ctrl: RTL and testbench
=================================

Name: btn_input_ctrl

Overview:
- Parametrised push-button front end between the board buttons and the MIPS CPU's memory-mapped input port.
- Replaces direct sampling of the raw `btn` bus.
- Each of NUM_BTN channels is synchronised and debounced, then produces:
  - a clean level
  - press/release pulses
  - a toggle state
  - a sticky pending flag
- The CPU clears pending flags with a mask handshake. An interrupt request is raised while any enabled flag is pending.

Parameters:
- NUM_BTN, 5, number of button channels.
- DEBOUNCE_CYCLES, 250000, cycles the synchronised input must hold a new value before it is accepted (5 ms at 50 MHz). Legal range is 1 or more.
- SYNC_STAGES, 2, synchroniser flop depth. Legal range is 2 or more.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width. Derived; never overridden.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous reset, active-low (rst==0 resets on the next posedge).
- btn_raw  in  NUM_BTN  asynchronous raw button inputs, active-high.
- irq_mask  in  NUM_BTN  per-channel interrupt enable.
- clr_valid  in  1  qualifies clr_mask for one cycle.
- clr_mask  in  NUM_BTN  pending bits to clear when clr_valid=1.
- btn_level  out  NUM_BTN  debounced level.
- btn_press  out  NUM_BTN  one-cycle pulse on a debounced 0->1 transition.
- btn_release  out  NUM_BTN  one-cycle pulse on a debounced 1->0 transition.
- btn_toggle  out  NUM_BTN  flips on every press.
- pending  out  NUM_BTN  sticky press flag.
- irq  out  1  |(pending & irq_mask), registered.

Behaviour:
- Reset (rst==0 at posedge): synchroniser flops, counters, btn_level, btn_press, btn_release, btn_toggle, pending and irq all go to 0.
  - A debounce in progress is discarded.
  - A button held through reset is reported as a press once reset is released: it goes through the full synchroniser plus debounce latency after rst returns to 1.
- Synchroniser: SYNC_STAGES flops per channel, output s.
- Per-channel debounce counter cnt:
  - If s==btn_level: cnt<=0.
  - Else if cnt==DEBOUNCE_CYCLES-1: btn_level<=s and cnt<=0.
  - Else: cnt<=cnt+1.
  - Any bounce back to the stable value restarts the count from 0.
  - The counter saturates by construction and never wraps.
- Latency: a clean raw edge is seen on btn_level after SYNC_STAGES+DEBOUNCE_CYCLES posedges.
- btn_press and btn_release:
  - Registered; high for exactly one cycle, the same cycle btn_level first shows the new value.
  - Never both high on one channel.
- btn_toggle: inverts in the same cycle btn_press is high.
- pending:
  - Set by btn_press.
  - Cleared when clr_valid=1 and clr_mask bit=1.
  - Set and clear in the same cycle on the same channel: set wins and pending stays 1, so no press is lost.
  - clr_mask bits with clr_valid=0 are ignored.
  - Clearing a bit that is already 0 has no effect.
- irq: registered OR of (pending & irq_mask), valid one cycle after pending changes. Changing irq_mask affects irq on the next cycle.
- DEBOUNCE_CYCLES=1: level follows s with one cycle of delay; any s change lasting at least one cycle is accepted.
- Channels are fully independent. Simultaneous events on different channels are all reported in the same cycle.

Decomposition:
- Shared package (cpu_io_pkg):
  - default debounce constant DEBOUNCE_5MS_50MHZ = 250000
  - simulation constant DEBOUNCE_SIM = 4
  - BTN_IDX constants for the 5 board buttons
- Sub-module btn_debounce_ch: one channel containing synchroniser, counter, level, press/release/toggle. Instantiated NUM_BTN times via generate.
- Pending/clear/irq logic lives in btn_input_ctrl.

Test Plan (DEBOUNCE_CYCLES=4, SYNC_STAGES=2, NUM_BTN=5):
- Reset with btn_raw=5'b01000 held, rst=0 for 5 cycles:
  - During reset, all outputs are 0.
  - 6 cycles after rst=1: btn_level[3]=1, with btn_press[3] and pending[3] pulsing/setting in that same cycle.
  - btn_toggle[3]=1.
- Bounce: btn_raw[0] toggles 1,0,1,0 every 2 cycles, then holds 1.
  - btn_press[0] occurs exactly once, 6 cycles after the final rise.
  - No pulse occurs during the bounce.
- Release: btn_raw[3] drops to 0 and holds.
  - btn_release[3] pulses for one cycle, 6 cycles later.
  - btn_level[3]=0.
  - pending[3] stays 1.
- Set/clear collision: clr_valid=1, clr_mask=5'b00001 in the same cycle as btn_press[0].
  - pending[0] remains 1.
  - Repeating the clear one cycle later gives pending[0]=0.
- irq: pending=5'b01001, irq_mask=5'b00001 gives irq=1.
  - Clear bit 0 -> irq=0 one cycle after pending[0] falls.
  - Set irq_mask=5'b01000 -> irq=1 next cycle.
- Mid-debounce reset: assert rst=0 two cycles into a press debounce.
  - No btn_press occurs.
  - After release of reset with the button still held, the press is reported 6 cycles later.

Source files
------------

// File: rtl/cpu_io_pkg.sv
// Shared constants and types for the CPU memory-mapped I/O blocks.
// Board button indices and debounce defaults live here so software-facing code agrees.
package cpu_io_pkg;

  localparam int DEBOUNCE_5MS_50MHZ = 250000;
  localparam int DEBOUNCE_SIM       = 4;
  localparam int NUM_BOARD_BTN      = 5;

  localparam int BTN_IDX_CENTER = 0;
  localparam int BTN_IDX_UP     = 1;
  localparam int BTN_IDX_LEFT   = 2;
  localparam int BTN_IDX_RIGHT  = 3;
  localparam int BTN_IDX_DOWN   = 4;

  // Per-channel debounced outputs; 'rel' is the release pulse.
  typedef struct packed {
    logic level;
    logic press;
    logic rel;
    logic toggle;
  } btn_evt_t;

endpackage

// File: rtl/btn_input_ctrl_if.sv
// Bus between the button front end (slave) and the CPU I/O port (master).
interface btn_input_ctrl_if #(
  parameter int NUM_BTN = 5
);

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] irq_mask;
  logic               clr_valid;
  logic [NUM_BTN-1:0] clr_mask;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;
  logic [NUM_BTN-1:0] btn_release;
  logic [NUM_BTN-1:0] btn_toggle;
  logic [NUM_BTN-1:0] pending;
  logic               irq;

  modport master (
    output btn_raw, irq_mask, clr_valid, clr_mask,
    input  btn_level, btn_press, btn_release, btn_toggle, pending, irq
  );

  modport slave (
    input  btn_raw, irq_mask, clr_valid, clr_mask,
    output btn_level, btn_press, btn_release, btn_toggle, pending, irq
  );

endinterface

// File: rtl/btn_debounce_ch.sv
// One button channel: synchroniser, debounce counter, clean level and edge/toggle outputs.
// press_evt is the unregistered accept-and-rising condition, used to set pending on the same edge.
module btn_debounce_ch
  import cpu_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_5MS_50MHZ,
  parameter int SYNC_STAGES     = 2
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     raw,
  output btn_evt_t evt,
  output logic     press_evt
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   level_q;
  logic                   press_q;
  logic                   release_q;
  logic                   toggle_q;
  logic                   s;
  logic                   accept;

  assign s         = sync_q[SYNC_STAGES-1];
  assign accept    = (s != level_q) && (cnt_q == CNT_LAST);
  assign press_evt = accept & s;

  // NOTE: non-blocking assignments so every flop here samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q    <= '0;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      toggle_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};

      // Any return to the stable value restarts the count, so the counter never exceeds CNT_LAST.
      if (s == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        level_q <= s;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end

      press_q   <= accept & s;
      release_q <= accept & ~s;
      if (press_evt) toggle_q <= ~toggle_q;
    end
  end

  assign evt = '{level: level_q, press: press_q, rel: release_q, toggle: toggle_q};

endmodule

// File: rtl/btn_input_ctrl.sv
// Push-button front end for the CPU input port: per-channel debounce plus sticky
// pending flags with a masked clear handshake and a registered interrupt request.
module btn_input_ctrl
  import cpu_io_pkg::*;
#(
  parameter int NUM_BTN         = NUM_BOARD_BTN,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_5MS_50MHZ,
  parameter int SYNC_STAGES     = 2
) (
  input logic             clk,
  input logic             rst,
  btn_input_ctrl_if.slave bus
);

  btn_evt_t           evt [NUM_BTN];
  logic [NUM_BTN-1:0] press_evt;
  logic [NUM_BTN-1:0] level_v;
  logic [NUM_BTN-1:0] press_v;
  logic [NUM_BTN-1:0] release_v;
  logic [NUM_BTN-1:0] toggle_v;
  logic [NUM_BTN-1:0] clr_eff;
  logic [NUM_BTN-1:0] pending_q;
  logic               irq_q;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .raw       (bus.btn_raw[i]),
      .evt       (evt[i]),
      .press_evt (press_evt[i])
    );
  end

  // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    level_v   = '0;
    press_v   = '0;
    release_v = '0;
    toggle_v  = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      level_v[i]   = evt[i].level;
      press_v[i]   = evt[i].press;
      release_v[i] = evt[i].rel;
      toggle_v[i]  = evt[i].toggle;
    end
  end

  assign clr_eff = bus.clr_valid ? bus.clr_mask : '0;

  // Set is OR-ed in after the clear, so a press colliding with a clear is never lost.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pending_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      pending_q <= (pending_q & ~clr_eff) | press_evt;
      irq_q     <= |(pending_q & bus.irq_mask);
    end
  end

  assign bus.btn_level   = level_v;
  assign bus.btn_press   = press_v;
  assign bus.btn_release = release_v;
  assign bus.btn_toggle  = toggle_v;
  assign bus.pending     = pending_q;
  assign bus.irq         = irq_q;

endmodule

// File: tb/tb_btn_input_ctrl.sv
// Scoreboard bench for btn_input_ctrl: a window-based reference model predicts every cycle's
// outputs, a negedge monitor compares them, and directed checks cover the key scenarios.
module tb_btn_input_ctrl;
  import cpu_io_pkg::*;

  localparam int NB  = 5;
  localparam int DEB = DEBOUNCE_SIM;
  localparam int SS  = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  btn_input_ctrl_if #(.NUM_BTN(NB)) bif ();

  btn_input_ctrl #(
    .NUM_BTN         (NB),
    .DEBOUNCE_CYCLES (DEB),
    .SYNC_STAGES     (SS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  typedef struct packed {
    logic [NB-1:0] level;
    logic [NB-1:0] press;
    logic [NB-1:0] rel;
    logic [NB-1:0] toggle;
    logic [NB-1:0] pending;
    logic          irq;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a new level is accepted once the synchronised input has disagreed with
  // the current level for DEB consecutive samples since the last reset.
  logic [NB-1:0] m_sync [SS];
  logic [NB-1:0] m_hist [$];
  logic [NB-1:0] m_level, m_toggle, m_pend;
  logic          m_irq;

  always @(posedge clk) begin : model
    logic [NB-1:0] s, press, rel, clr;
    logic          flip;
    exp_t          e;
    press = '0;
    rel   = '0;
    if (!rst) begin
      for (int k = 0; k < SS; k++) m_sync[k] = '0;
      m_hist.delete();
      m_level  = '0;
      m_toggle = '0;
      m_pend   = '0;
      m_irq    = 1'b0;
    end else begin
      s = m_sync[SS-1];
      for (int k = SS - 1; k > 0; k--) m_sync[k] = m_sync[k-1];
      m_sync[0] = bif.btn_raw;
      m_hist.push_back(s);
      if (m_hist.size() > DEB) void'(m_hist.pop_front());
      for (int ch = 0; ch < NB; ch++) begin
        if (m_hist.size() == DEB) begin
          flip = 1'b1;
          foreach (m_hist[j]) if (m_hist[j][ch] == m_level[ch]) flip = 1'b0;
          if (flip) begin
            if (m_level[ch]) rel[ch] = 1'b1;
            else             press[ch] = 1'b1;
          end
        end
      end
      clr      = bif.clr_valid ? bif.clr_mask : '0;
      m_irq    = |(m_pend & bif.irq_mask);
      m_pend   = (m_pend & ~clr) | press;
      m_level  = m_level ^ (press | rel);
      m_toggle = m_toggle ^ press;
    end
    e = '{level: m_level, press: press, rel: rel, toggle: m_toggle, pending: m_pend, irq: m_irq};
    sb_q.push_back(e);
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("sb_level",   bif.btn_level,   e.level);
      check("sb_press",   bif.btn_press,   e.press);
      check("sb_release", bif.btn_release, e.rel);
      check("sb_toggle",  bif.btn_toggle,  e.toggle);
      check("sb_pending", bif.pending,     e.pending);
      check("sb_irq",     bif.irq,         e.irq);
    end
  end

  int p0 = 0;

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      if (bif.btn_press[0] === 1'b1) p0++;
    end
  endtask

  initial begin
    rst           = 1'b0;
    bif.btn_raw   = 5'b01000;
    bif.irq_mask  = '0;
    bif.clr_valid = 1'b0;
    bif.clr_mask  = '0;

    // Button 3 held through reset
    step(5);
    check("reset_outputs", {bif.btn_level, bif.btn_press, bif.btn_release,
                            bif.btn_toggle, bif.pending, bif.irq}, '0);
    rst = 1'b1;
    step(5);
    check("held_press_early", bif.btn_press[3], 1'b0);
    step(1);
    check("held_level",   bif.btn_level[3],  1'b1);
    check("held_press",   bif.btn_press[3],  1'b1);
    check("held_pending", bif.pending[3],    1'b1);
    check("held_toggle",  bif.btn_toggle[3], 1'b1);

    // Bounce on channel 0, then a collision of press and clear
    p0 = 0;
    for (int k = 0; k < 4; k++) begin
      bif.btn_raw[0] = (k % 2 == 0);
      step(2);
    end
    bif.btn_raw[0] = 1'b1;
    step(5);
    check("bounce_no_press", p0, 0);
    bif.clr_valid = 1'b1;
    bif.clr_mask  = 5'b00001;
    step(1);
    check("bounce_press",     bif.btn_press[0], 1'b1);
    check("collide_pending",  bif.pending[0],   1'b1);
    step(1);
    check("clear_pending",    bif.pending[0],   1'b0);
    bif.clr_valid = 1'b0;
    bif.clr_mask  = '0;
    step(3);
    check("bounce_press_once", p0, 1);

    // Release of channel 3
    bif.btn_raw[3] = 1'b0;
    step(5);
    check("release_early", bif.btn_release[3], 1'b0);
    step(1);
    check("release_pulse",   bif.btn_release[3], 1'b1);
    check("release_level",   bif.btn_level[3],   1'b0);
    check("release_pending", bif.pending[3],     1'b1);
    step(1);
    check("release_one_cycle", bif.btn_release[3], 1'b0);

    // irq masking and clearing
    bif.btn_raw[0] = 1'b0;
    step(8);
    bif.btn_raw[0] = 1'b1;
    step(6);
    check("irq_pending", bif.pending, 5'b01001);
    bif.irq_mask = 5'b00001;
    step(1);
    check("irq_set", bif.irq, 1'b1);
    bif.clr_valid = 1'b1;
    bif.clr_mask  = 5'b00001;
    step(1);
    bif.clr_valid = 1'b0;
    bif.clr_mask  = '0;
    check("irq_clear_pending", bif.pending[0], 1'b0);
    check("irq_lags_pending",  bif.irq,        1'b1);
    step(1);
    check("irq_cleared", bif.irq, 1'b0);
    bif.irq_mask = 5'b01000;
    step(1);
    check("irq_remask", bif.irq, 1'b1);

    // Reset in the middle of a press debounce on channel 2
    bif.btn_raw[2] = 1'b1;
    step(4);
    rst = 1'b0;
    step(3);
    check("midrst_level", bif.btn_level[2], 1'b0);
    rst = 1'b1;
    step(5);
    check("midrst_press_early", bif.btn_press[2], 1'b0);
    step(1);
    check("midrst_press", bif.btn_press[2], 1'b1);

    // Randomised traffic, checked by the scoreboard
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int b = 0; b < NB; b++)
        if ($urandom_range(7) == 0) bif.btn_raw[b] = ~bif.btn_raw[b];
      if ($urandom_range(49) == 0) bif.irq_mask = NB'($urandom);
      bif.clr_valid = ($urandom_range(9) == 0);
      bif.clr_mask  = NB'($urandom);
      rst = ($urandom_range(499) != 0);
      step(1);
    end
    rst           = 1'b1;
    bif.clr_valid = 1'b0;
    step(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
